// File: rtl/jt12_mmr_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | jt12_mmr_pkg : register map constants and queue entry type for jt12_mmr |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package jt12_mmr_pkg;

  // Global (bank-independent) registers
  localparam logic [7:0] REG_TEST       = 8'h21;
  localparam logic [7:0] REG_LFO        = 8'h22;
  localparam logic [7:0] REG_TIMER_A_HI = 8'h24;
  localparam logic [7:0] REG_TIMER_A_LO = 8'h25;
  localparam logic [7:0] REG_TIMER_B    = 8'h26;
  localparam logic [7:0] REG_TIMER_CTRL = 8'h27;
  localparam logic [7:0] REG_KEY_ON     = 8'h28;
  localparam logic [7:0] REG_DAC        = 8'h2A;
  localparam logic [7:0] REG_DAC_EN     = 8'h2B;
  localparam logic [7:0] REG_GLOBAL_END = 8'h2F;

  localparam logic [7:0] CH_REG_BASE    = 8'h30;
  localparam logic [7:0] FREQ_REG_BASE  = 8'hA0;

  // Entry bank field is sized for up to 16 banks
  localparam int ENTRY_BANK_W = 4;

  typedef struct packed {
    logic [ENTRY_BANK_W-1:0] bank;
    logic [7:0]              reg_num;
    logic [7:0]              data;
  } wr_entry_t;

  function automatic int bw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_mmr_queue_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | jt12_mmr_queue_if : CPU port and register-file port bundle              |
// | Shadow read signals exist only with JT12_MMR_SHADOW_EN. Rev 1.0          |
// +-------------------------------------------------------------------------+
interface jt12_mmr_queue_if #(
  parameter int BANKS       = 2,
  parameter int CH_PER_BANK = 3
);
  localparam int BW  = jt12_mmr_pkg::bw_of(BANKS);
  localparam int CHW = jt12_mmr_pkg::bw_of(BANKS * CH_PER_BANK);

  logic           cpu_write;
  logic [BW:0]    cpu_addr;
  logic [7:0]     cpu_din;
  logic           cpu_busy;
  logic           full;
  logic           overflow;
  logic           ovf_clr;
  logic           wr_valid;
  logic           wr_ready;
  logic [7:0]     wr_reg;
  logic [7:0]     wr_data;
  logic [BW-1:0]  wr_bank;
  logic           wr_global;
  logic [CHW-1:0] wr_ch;
  logic [1:0]     wr_op;
`ifdef JT12_MMR_SHADOW_EN
  logic [8+BW-1:0] rd_addr;
  logic [7:0]      rd_data;

  modport slave (
    input  cpu_write, cpu_addr, cpu_din, ovf_clr, wr_ready, rd_addr,
    output cpu_busy, full, overflow, wr_valid, wr_reg, wr_data, wr_bank,
           wr_global, wr_ch, wr_op, rd_data
  );
  modport master (
    output cpu_write, cpu_addr, cpu_din, ovf_clr, wr_ready, rd_addr,
    input  cpu_busy, full, overflow, wr_valid, wr_reg, wr_data, wr_bank,
           wr_global, wr_ch, wr_op, rd_data
  );
`else
  modport slave (
    input  cpu_write, cpu_addr, cpu_din, ovf_clr, wr_ready,
    output cpu_busy, full, overflow, wr_valid, wr_reg, wr_data, wr_bank,
           wr_global, wr_ch, wr_op
  );
  modport master (
    output cpu_write, cpu_addr, cpu_din, ovf_clr, wr_ready,
    input  cpu_busy, full, overflow, wr_valid, wr_reg, wr_data, wr_bank,
           wr_global, wr_ch, wr_op
  );
`endif
endinterface
`default_nettype wire

// File: rtl/jt12_mmr_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | jt12_mmr_fifo : DEPTH x WIDTH FIFO, head read straight from flop storage |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module jt12_mmr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         din,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         dout,
  output logic                          valid,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          drop
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full    = (count_q == (PW+1)'(DEPTH));
    do_pop  = pop & (count_q != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle
    do_push = push & (~full | do_pop);
    drop    = push & full & ~do_pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/jt12_mmr_queue.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | jt12_mmr_queue : YM2612 CPU write front end with busy emulation, write  |
// | FIFO and field decode. Optional shadow RAM: JT12_MMR_SHADOW_EN. Rev 1.0 |
// +-------------------------------------------------------------------------+
module jt12_mmr_queue
  import jt12_mmr_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int BANKS       = 2,
  parameter int CH_PER_BANK = 3,
  parameter int BUSY_CYCLES = 32
) (
  input wire logic         clk,
  input wire logic         rst,
  jt12_mmr_queue_if.slave  bus
);
  localparam int BW    = bw_of(BANKS);
  localparam int CHW   = bw_of(BANKS * CH_PER_BANK);
  localparam int CNT_W = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;

  logic [7:0]       sel_reg_q, sel_reg_d;
  logic [BW-1:0]    sel_bank_q, sel_bank_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             overflow_q, overflow_d;

  logic             addr_wr, data_wr, bad_ch, push, drop, head_valid, pop_fire;
  wr_entry_t        push_entry, head;
  logic [$bits(wr_entry_t)-1:0] head_raw;
  logic [$clog2(DEPTH):0]       count;
  logic [BW-1:0]    head_bank;
  logic [15:0]      ch_sum;

  always_comb begin
    addr_wr = bus.cpu_write & ~bus.cpu_addr[0];
    data_wr = bus.cpu_write &  bus.cpu_addr[0];
    // Channel slot 3 of each bank does not exist on the chip
    bad_ch  = (sel_reg_q >= CH_REG_BASE) && (sel_reg_q[1:0] == 2'd3);
    push    = data_wr & ~bad_ch;

    push_entry.bank    = ENTRY_BANK_W'(sel_bank_q);
    push_entry.reg_num = sel_reg_q;
    push_entry.data    = bus.cpu_din;

    sel_reg_d  = sel_reg_q;
    sel_bank_d = sel_bank_q;
    if (addr_wr) begin
      sel_reg_d  = bus.cpu_din;
      sel_bank_d = bus.cpu_addr[BW:1];
    end

    busy_cnt_d = busy_cnt_q;
    if (data_wr) begin
      busy_cnt_d = CNT_W'(BUSY_CYCLES);
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end

    overflow_d = overflow_q;
    if (bus.ovf_clr) overflow_d = 1'b0;
    if (drop)        overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg_q  <= 8'h00;
      sel_bank_q <= '0;
      busy_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      sel_reg_q  <= sel_reg_d;
      sel_bank_q <= sel_bank_d;
      busy_cnt_q <= busy_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  jt12_mmr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wr_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (bus.wr_ready),
    .dout  (head_raw),
    .valid (head_valid),
    .count (count),
    .drop  (drop)
  );

  always_comb begin
    head      = wr_entry_t'(head_raw);
    head_bank = head.bank[BW-1:0];
    pop_fire  = head_valid & bus.wr_ready;
    ch_sum    = 16'(head_bank) * 16'(CH_PER_BANK) + 16'(head.reg_num[1:0]);
  end

  assign bus.cpu_busy  = (busy_cnt_q != '0);
  assign bus.full      = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign bus.overflow  = overflow_q;
  assign bus.wr_valid  = head_valid;
  assign bus.wr_reg    = head.reg_num;
  assign bus.wr_data   = head.data;
  assign bus.wr_bank   = head_bank;
  assign bus.wr_global = (head.reg_num < CH_REG_BASE);
  assign bus.wr_ch     = ch_sum[CHW-1:0];
  assign bus.wr_op     = head.reg_num[3:2];

  logic unused_bits;
  assign unused_bits = ^{ch_sum[15:CHW], head.bank[ENTRY_BANK_W-1:BW]};

`ifdef JT12_MMR_SHADOW_EN
  localparam int SH_DEPTH = BANKS * 256;

  logic [7:0]      shadow_ram [SH_DEPTH];
  logic [8+BW-1:0] shadow_wa;
  logic [7:0]      rd_data_q, rd_data_d;

  assign shadow_wa = {head_bank, head.reg_num};

  // RAM contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (pop_fire && (int'(shadow_wa) < SH_DEPTH)) begin
      shadow_ram[shadow_wa] <= head.data;
    end
  end

  always_comb begin
    rd_data_d = 8'h00;
    if (int'(bus.rd_addr) < SH_DEPTH) rd_data_d = shadow_ram[bus.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= 8'h00;
    else     rd_data_q <= rd_data_d;
  end

  assign bus.rd_data = rd_data_q;
`else
  logic unused_pop;
  assign unused_pop = pop_fire;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jt12_mmr_queue.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_jt12_mmr_queue : directed vectors for jt12_mmr_queue (defaults:      |
// | DEPTH=4, BANKS=2, CH_PER_BANK=3, BUSY_CYCLES=32). Rev 1.0               |
// +-------------------------------------------------------------------------+
module tb_jt12_mmr_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  jt12_mmr_queue_if bus ();

  jt12_mmr_queue u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    bus.cpu_write = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_din   = d;
    tick();
    bus.cpu_write = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.cpu_busy && n < 200) begin
      tick();
      n++;
    end
    check("busy_timeout", 32'(bus.cpu_busy), 32'd0);
  endtask

  logic [7:0] dvec [5];
  int n;

  initial begin
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_din   = '0;
    bus.ovf_clr   = 1'b0;
    bus.wr_ready  = 1'b0;
`ifdef JT12_MMR_SHADOW_EN
    bus.rd_addr   = '0;
`endif
    repeat (3) tick();
    check("rst_valid",    32'(bus.wr_valid), 32'd0);
    check("rst_busy",     32'(bus.cpu_busy), 32'd0);
    check("rst_full",     32'(bus.full),     32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Key-on write: 1-cycle latency, 32-cycle busy window
    bus.wr_ready = 1'b1;
    cpu_wr(2'b00, 8'h28);
    check("addr_no_busy", 32'(bus.cpu_busy), 32'd0);
    check("addr_no_push", 32'(bus.wr_valid), 32'd0);
    cpu_wr(2'b01, 8'hF1);
    check("ko_valid",  32'(bus.wr_valid),  32'd1);
    check("ko_reg",    32'(bus.wr_reg),    32'h28);
    check("ko_data",   32'(bus.wr_data),   32'hF1);
    check("ko_global", 32'(bus.wr_global), 32'd1);
    check("ko_busy",   32'(bus.cpu_busy),  32'd1);
    tick();
    check("ko_popped", 32'(bus.wr_valid), 32'd0);
    n = 1;
    while (bus.cpu_busy && n < 100) begin
      n++;
      tick();
    end
    check("busy_len", 32'(n), 32'd32);

    // Bank 1 decode
    bus.wr_ready = 1'b0;
    cpu_wr(2'b10, 8'hA2);
    cpu_wr(2'b11, 8'h55);
    check("a2_valid",  32'(bus.wr_valid),  32'd1);
    check("a2_reg",    32'(bus.wr_reg),    32'hA2);
    check("a2_data",   32'(bus.wr_data),   32'h55);
    check("a2_bank",   32'(bus.wr_bank),   32'd1);
    check("a2_ch",     32'(bus.wr_ch),     32'd5);
    check("a2_global", 32'(bus.wr_global), 32'd0);
    tick();
    check("a2_hold",   32'(bus.wr_data),   32'h55);
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    check("a2_popped", 32'(bus.wr_valid), 32'd0);
    cpu_wr(2'b10, 8'h4C);
    cpu_wr(2'b11, 8'h7F);
    check("4c_reg", 32'(bus.wr_reg), 32'h4C);
    check("4c_op",  32'(bus.wr_op),  32'd3);
    check("4c_ch",  32'(bus.wr_ch),  32'd3);
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;

    // Fill, overflow (set beats simultaneous clear), ordered drain
    dvec[0] = 8'hD0; dvec[1] = 8'hD1; dvec[2] = 8'hD2; dvec[3] = 8'hD3; dvec[4] = 8'hD4;
    cpu_wr(2'b00, 8'h30);
    for (int i = 0; i < 4; i++) cpu_wr(2'b01, dvec[i]);
    check("fill_full", 32'(bus.full),     32'd1);
    check("fill_ovf",  32'(bus.overflow), 32'd0);
    bus.ovf_clr = 1'b1;
    cpu_wr(2'b01, dvec[4]);
    bus.ovf_clr = 1'b0;
    check("drop_ovf", 32'(bus.overflow), 32'd1);
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(bus.wr_valid), 32'd1);
      check("drain_data",  32'(bus.wr_data),  32'(dvec[i]));
      tick();
    end
    check("drain_empty",  32'(bus.wr_valid), 32'd0);
    check("ovf_sticky",   32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared",  32'(bus.overflow), 32'd0);

    // Nonexistent channel slot: dropped silently, still busy
    bus.wr_ready = 1'b0;
    wait_idle();
    cpu_wr(2'b00, 8'h33);
    cpu_wr(2'b01, 8'h12);
    check("bad_valid", 32'(bus.wr_valid), 32'd0);
    check("bad_ovf",   32'(bus.overflow), 32'd0);
    check("bad_busy",  32'(bus.cpu_busy), 32'd1);

    // Push and pop on a single-entry FIFO: no bubble
    cpu_wr(2'b00, 8'h40);
    cpu_wr(2'b01, 8'h11);
    bus.wr_ready = 1'b1;
    cpu_wr(2'b01, 8'h22);
    check("pp1_valid", 32'(bus.wr_valid), 32'd1);
    check("pp1_data",  32'(bus.wr_data),  32'h22);
    tick();
    check("pp1_empty", 32'(bus.wr_valid), 32'd0);

    // Full with same-cycle push and pop
    bus.wr_ready = 1'b0;
    dvec[0] = 8'hE0; dvec[1] = 8'hE1; dvec[2] = 8'hE2; dvec[3] = 8'hE3; dvec[4] = 8'hE4;
    for (int i = 0; i < 4; i++) cpu_wr(2'b01, dvec[i]);
    bus.wr_ready = 1'b1;
    cpu_wr(2'b01, dvec[4]);
    bus.wr_ready = 1'b0;
    check("ppf_full", 32'(bus.full),     32'd1);
    check("ppf_ovf",  32'(bus.overflow), 32'd0);
    check("ppf_head", 32'(bus.wr_data),  32'hE1);
    bus.wr_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("ppf_drain", 32'(bus.wr_data), 32'(dvec[i]));
      tick();
    end
    check("ppf_empty", 32'(bus.wr_valid), 32'd0);

    // Reset with entries queued flushes everything
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) cpu_wr(2'b01, dvec[i]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_valid", 32'(bus.wr_valid), 32'd0);
    check("rst2_busy",  32'(bus.cpu_busy), 32'd0);
    check("rst2_full",  32'(bus.full),     32'd0);

`ifdef JT12_MMR_SHADOW_EN
    cpu_wr(2'b10, 8'hB4);
    cpu_wr(2'b11, 8'hC0);
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    bus.rd_addr = {1'b1, 8'hB4};
    tick();
    check("shadow_rd", 32'(bus.rd_data), 32'hC0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
